// File: rtl/univ_shift_reg.sv
// Purpose : WIDTH-bit register with load, shift, rotate, increment and decrement,
//           a registered carry/borrow flag and a zero flag.
// Latency : 1 cycle. An operation applied on an edge is visible in Q and carry
//           right after that edge.
// Backpr. : none. en=0 freezes all state. Back-to-back operations every cycle
//           are supported.
//
// Ports:
//   clk   - clock; all state changes on the rising edge
//   R     - synchronous active-high reset (Q <= RESET_VAL, carry <= 0)
//   en    - clock enable; 0 holds Q and carry
//   mode  - 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 INC, 111 DEC
//   D     - parallel load data
//   sin   - serial input for SHL/SHR
//   Q     - register contents
//   sout  - bit the next shift/rotate in the selected direction will push out
//   carry - registered carry/borrow/shifted-out bit
//   zero  - 1 when Q == 0
module univ_shift_reg #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic             clk,
  input  logic             R,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin,
  output logic [WIDTH-1:0] Q,
  output logic             sout,
  output logic             carry,
  output logic             zero
);

  localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_INC  = 3'b110;
  localparam logic [2:0] M_DEC  = 3'b111;

  logic [WIDTH-1:0] q_nxt;
  logic             c_nxt;

  // Next-state selection. en gates everything so a disabled cycle is a plain hold.
  always_comb begin
    q_nxt = Q;
    c_nxt = carry;
    if (en) begin
      case (mode)
        M_HOLD: begin
          q_nxt = Q;
          c_nxt = carry;
        end
        M_LOAD: begin
          q_nxt = D;
          c_nxt = 1'b0;
        end
        M_SHL: begin
          q_nxt = {Q[WIDTH-2:0], sin};
          c_nxt = Q[WIDTH-1];
        end
        M_SHR: begin
          q_nxt = {sin, Q[WIDTH-1:1]};
          c_nxt = Q[0];
        end
        M_ROL: begin
          q_nxt = {Q[WIDTH-2:0], Q[WIDTH-1]};
          c_nxt = Q[WIDTH-1];
        end
        M_ROR: begin
          q_nxt = {Q[0], Q[WIDTH-1:1]};
          c_nxt = Q[0];
        end
        // Carry out of an increment only happens when every bit is set.
        M_INC: begin
          q_nxt = Q + ONE;
          c_nxt = &Q;
        end
        // Borrow out of a decrement only happens from zero.
        M_DEC: begin
          q_nxt = Q - ONE;
          c_nxt = ~|Q;
        end
        default: begin
          q_nxt = Q;
          c_nxt = carry;
        end
      endcase
    end
  end

  // Reset has priority over enable and mode.
  always_ff @(posedge clk) begin
    if (R) begin
      Q     <= RST_Q;
      carry <= 1'b0;
    end else begin
      Q     <= q_nxt;
      carry <= c_nxt;
    end
  end

  // Left-moving modes expose the MSB, everything else the LSB.
  assign sout = ((mode == M_SHL) || (mode == M_ROL)) ? Q[WIDTH-1] : Q[0];
  assign zero = ~|Q;

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised synchronous register for datapath storage, serial conversion and simple counting.
It generalises the plain fixed-width reset/load register to WIDTH bits.
It adds clock enable, eight operating modes, serial in/out, a registered carry/borrow flag and a zero flag.
It sits between lab datapath blocks wherever a value must be held, shifted, rotated or counted.

Parameters:
WIDTH, 8, data width in bits; legal range 2..32
RESET_VAL, 0, value loaded into Q on reset; truncated to WIDTH bits

Ports:
clk  input  1  clock; all state changes on the rising edge
R  input  1  reset, synchronous, active-high
en  input  1  clock enable; 0 = all state holds
mode  input  3  operation select, decoded per Behaviour
D  input  WIDTH  parallel load data
sin  input  1  serial input bit for the shift modes
Q  output  WIDTH  register contents
sout  output  1  serial output bit
carry  output  1  registered carry/borrow/shifted-out bit
zero  output  1  1 when Q == 0

Behaviour:
- All state is Q and carry, updated only on posedge clk. There is no asynchronous path to either.
- Priority per edge: R, then en, then mode.
- R=1: Q <= RESET_VAL, carry <= 0. This applies regardless of en and mode, and mid-operation.
- R=0, en=0: Q and carry hold.
- R=0, en=1, mode decode:
  - 000 HOLD: Q holds, carry holds.
  - 001 LOAD: Q <= D, carry <= 0.
  - 010 SHL: Q <= {Q[W-2:0], sin}, carry <= Q[W-1].
  - 011 SHR: Q <= {sin, Q[W-1:1]}, carry <= Q[0].
  - 100 ROL: Q <= {Q[W-2:0], Q[W-1]}, carry <= Q[W-1].
  - 101 ROR: Q <= {Q[0], Q[W-1:1]}, carry <= Q[0].
  - 110 INC: Q <= Q+1 modulo 2^W. carry <= 1 only when old Q was all ones (wrap to 0), else 0.
  - 111 DEC: Q <= Q-1 modulo 2^W. carry <= 1 only when old Q was 0 (wrap to all ones), else 0.
- Latency: every operation takes 1 cycle; the new Q is visible the cycle after the edge.
- Back-to-back operations on consecutive cycles are fully supported.
- sout is combinational from current Q and mode:
  - sout = Q[W-1] when mode is 010 or 100.
  - sout = Q[0] for all other modes.
  - This gives the bit that the next SHL/ROL or SHR/ROR edge will shift out.
- zero is combinational: zero = (Q == 0). It is independent of en and mode.
- Values after reset: Q = RESET_VAL, carry = 0, zero = (RESET_VAL == 0). sout follows the rule above.
- With R asserted for several cycles, outputs stay at their reset values. Operation resumes on the first edge with R=0.
- All arithmetic is unsigned, WIDTH bits. There is no saturation.
- Undefined behaviour is not permitted: every mode code is defined.

Test Plan (WIDTH=8, RESET_VAL=0 unless stated):
- Reset: R=1 for 2 edges with en=1, mode=110 -> Q=0x00, carry=0, zero=1. Then R=0 with one INC edge -> Q=0x01, zero=0.
- Load/hold/enable: LOAD D=0xA5 -> Q=0xA5, carry=0. Next, en=0 with mode=110 for 3 edges -> Q stays 0xA5. Then HOLD -> Q stays 0xA5.
- Shift: Q=0x81, SHL with sin=0 -> Q=0x02, carry=1. Then SHR with sin=1 -> Q=0x81, carry=0. Check sout=Q[7] during SHL and Q[0] during SHR.
- Rotate: Q=0x81, ROL -> Q=0x03, carry=1. ROR from 0x03 -> Q=0x81, carry=1. Eight consecutive ROLs from 0x5A -> Q returns to 0x5A.
- Wrap: LOAD 0xFF, INC -> Q=0x00, carry=1, zero=1. INC again -> Q=0x01, carry=0. DEC twice -> Q=0xFF, carry=1.
- Reset mid-count with RESET_VAL=0x3C: INC 5 edges from 0x3C -> Q=0x41. Assert R for one edge while en=1, mode=110 -> Q=0x3C, carry=0. The next INC edge -> Q=0x3D.
